// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: ADD/SUB/NEG through one shared adder with a
// conditional word inverter, unsigned MUL as WIDTH shift-add iterations.
module alu_seq_ctrl #(
   parameter int WIDTH = 17,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      EXEC,
      DONE
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_NEG = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] opbx;
   logic             inv;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] acc_lo_nx;
   logic [WIDTH-1:0] acc_hi_nx;
   logic             ovf_add;

   assign start_ready = (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign busy        = (state_q != IDLE);

   // result/result_hi double as the {acc_hi, acc_lo} shift register during MUL
   always_comb begin
      opa = a_q;
      opb = b_q;
      inv = 1'b0;
      unique case (1'b1)
         (state_q == EXEC): begin
            opa = result_hi;
            opb = result[0] ? a_q : '0;
         end
         (op_q == OP_NEG): begin
            opa = '0;
            opb = a_q;
            inv = 1'b1;
         end
         (op_q == OP_ADD): begin
            inv = 1'b0;
         end
         default: begin
            inv = 1'b1;
         end
      endcase
      opbx = opb ^ {WIDTH{inv}};
      sum  = {1'b0, opa} + {1'b0, opbx} + {{WIDTH{1'b0}}, inv};
      acc_hi_nx = sum[WIDTH:1];
      acc_lo_nx = {sum[0], result[WIDTH-1:1]};
      ovf_add = (opa[WIDTH-1] == opbx[WIDTH-1]) &&
                (sum[WIDTH-1] != opa[WIDTH-1]);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start_valid) state_d = PREP;
         PREP: state_d = (op_q == OP_MUL) ? EXEC : DONE;
         EXEC: if (cnt_q == '0) state_d = DONE;
         DONE: if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         result    <= '0;
         result_hi <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (start_valid) begin
                  op_q <= op;
                  a_q  <= a;
                  b_q  <= b;
               end
            end
            PREP: begin
               if (op_q == OP_MUL) begin
                  result    <= b_q;
                  result_hi <= '0;
                  cnt_q     <= CNT_LAST;
                  carry     <= 1'b0;
                  overflow  <= 1'b0;
                  zero      <= 1'b0;
               end else begin
                  result    <= sum[WIDTH-1:0];
                  result_hi <= '0;
                  carry     <= sum[WIDTH];
                  overflow  <= ovf_add;
                  zero      <= (sum[WIDTH-1:0] == '0);
               end
            end
            EXEC: begin
               result_hi <= acc_hi_nx;
               result    <= acc_lo_nx;
               if (cnt_q == '0) begin
                  overflow <= (acc_hi_nx != '0);
                  zero     <= (acc_hi_nx == '0) && (acc_lo_nx == '0);
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule
